// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, mode encodings and sweep FSM states for the DDS frequency path
package dds_pkg;
  localparam int CODE_W = 8;
  localparam int REF_HZ = 100000;
  localparam int ACC_SHIFT = 8;
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// freq_sweep_ctrl_if: control inputs and frequency outputs of the sweep controller
interface freq_sweep_ctrl_if #(parameter int DWELL_W = 16);
  import dds_pkg::*;
  mode_t mode;
  logic sweep_en;
  logic key_up;
  logic key_dn;
  logic [CODE_W-1:0] start_code;
  logic [CODE_W-1:0] stop_code;
  logic [CODE_W-1:0] step;
  logic [DWELL_W-1:0] dwell;
  logic [CODE_W-1:0] freq_ctrl;
  logic freq_upd;
  logic busy;
  logic [31:0] freq_hz;
  logic hz_valid;
  modport master(
    output mode, sweep_en, key_up, key_dn, start_code, stop_code, step, dwell,
    input freq_ctrl, freq_upd, busy, freq_hz, hz_valid
  );
  modport slave(
    input mode, sweep_en, key_up, key_dn, start_code, stop_code, step, dwell,
    output freq_ctrl, freq_upd, busy, freq_hz, hz_valid
  );
endinterface

// File: rtl/freq_hz_calc.sv
// freq_hz_calc: sequential shift-add of code*REF_HZ, result >> ACC_SHIFT, restartable by load
module freq_hz_calc import dds_pkg::*; (
  input  logic              clk_100kHz,
  input  logic              rst,
  input  logic              load,
  input  logic [CODE_W-1:0] code,
  output logic [31:0]       freq_hz,
  output logic              valid
);
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [CODE_W-1:0] mplier;
  logic [3:0] cnt;
  logic run;
  // a load always wins so a result from an older code is never published
  always_ff @(posedge clk_100kHz)
    if (rst) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      run <= 1'b0;
      freq_hz <= '0;
      valid <= 1'b1;
    end else if (load) begin
      acc <= '0;
      mcand <= 32'(REF_HZ);
      mplier <= code;
      cnt <= '0;
      run <= 1'b1;
      valid <= 1'b0;
    end else if (run) begin
      if (cnt == 4'(CODE_W)) begin
        freq_hz <= acc >> ACC_SHIFT;
        valid <= 1'b1;
        run <= 1'b0;
      end else begin
        acc <= acc + (mplier[0] ? mcand : '0);
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 4'd1;
      end
    end
endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: drives the DDS control word from keys, sawtooth or triangle sweeps
module freq_sweep_ctrl import dds_pkg::*; #(parameter int DWELL_W = 16) (
  input logic clk_100kHz,
  input logic rst,
  freq_sweep_ctrl_if.slave bus
);
  state_t state, state_nxt;
  mode_t mode_l;
  logic [CODE_W-1:0] ctrl, ctrl_nxt, start_l, stop_l, step_l, step_eff, up_code, dn_code;
  logic [DWELL_W-1:0] dwell_l, dwell_eff, cnt, cnt_nxt;
  logic [CODE_W:0] sum, diff;
  logic go, expire, abort, upd, upd_q;
  assign step_eff = bus.step == '0 ? CODE_W'(1) : bus.step;
  assign dwell_eff = bus.dwell == '0 ? DWELL_W'(1) : bus.dwell;
  assign go = state == IDLE && bus.sweep_en && (bus.mode == MODE_SAW || bus.mode == MODE_TRI);
  assign expire = cnt == dwell_l - DWELL_W'(1);
  assign abort = !bus.sweep_en || bus.mode != mode_l;
  // 9-bit arithmetic keeps the clamps free of wrap-around at both ends
  assign sum = {1'b0, ctrl} + {1'b0, step_l};
  assign diff = {1'b0, ctrl} - {1'b0, step_l};
  assign up_code = sum >= {1'b0, stop_l} ? stop_l : sum[CODE_W-1:0];
  assign dn_code = (diff[CODE_W] || diff[CODE_W-1:0] <= start_l) ? start_l : diff[CODE_W-1:0];
  always_comb begin
    state_nxt = state;
    ctrl_nxt = ctrl;
    cnt_nxt = cnt;
    if (state == IDLE) begin
      if (go) begin
        ctrl_nxt = bus.start_code;
        cnt_nxt = '0;
        state_nxt = bus.start_code < bus.stop_code ? UP : IDLE;
      end else if (bus.mode == MODE_MANUAL && bus.key_up != bus.key_dn)
        ctrl_nxt = bus.key_up ? (ctrl == '1 ? ctrl : ctrl + CODE_W'(1))
                              : (ctrl == '0 ? ctrl : ctrl - CODE_W'(1));
    end else if (abort)
      state_nxt = IDLE;
    else if (!expire)
      cnt_nxt = cnt + DWELL_W'(1);
    else begin
      cnt_nxt = '0;
      if (state == UP) begin
        ctrl_nxt = ctrl == stop_l ? start_l : up_code;
        state_nxt = (mode_l == MODE_TRI && up_code == stop_l) ? DOWN : UP;
      end else begin
        ctrl_nxt = dn_code;
        state_nxt = dn_code == start_l ? UP : DOWN;
      end
    end
  end
  assign upd = ctrl_nxt != ctrl;
  always_ff @(posedge clk_100kHz)
    if (rst) begin
      state <= IDLE;
      ctrl <= '0;
      cnt <= '0;
      upd_q <= 1'b0;
      mode_l <= MODE_MANUAL;
      start_l <= '0;
      stop_l <= '0;
      step_l <= '0;
      dwell_l <= '0;
    end else begin
      state <= state_nxt;
      ctrl <= ctrl_nxt;
      cnt <= cnt_nxt;
      upd_q <= upd;
      if (go) begin
        mode_l <= bus.mode;
        start_l <= bus.start_code;
        stop_l <= bus.stop_code;
        step_l <= step_eff;
        dwell_l <= dwell_eff;
      end
    end
  assign bus.freq_ctrl = ctrl;
  assign bus.freq_upd = upd_q;
  assign bus.busy = state != IDLE;
  // fed from the next-state word so the calculation starts on the same edge as freq_upd
  freq_hz_calc u_hz (
    .clk_100kHz(clk_100kHz),
    .rst(rst),
    .load(upd),
    .code(ctrl_nxt),
    .freq_hz(bus.freq_hz),
    .valid(bus.hz_valid)
  );
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed bench with a freq_upd scoreboard and timed Hz checks
module tb_freq_sweep_ctrl;
  import dds_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int model = 0;
  logic [7:0] exp_q[$];
  int saw_seq[5] = '{10, 14, 18, 20, 10};
  int tri_seq[8] = '{0, 100, 200, 255, 155, 55, 0, 100};
  freq_sweep_ctrl_if #(.DWELL_W(16)) dut_if();
  freq_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk_100kHz(clk),
    .rst(rst),
    .bus(dut_if.slave)
  );
  always #5 clk = ~clk;
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic expect_code(int v);
    if (v != model) exp_q.push_back(8'(v));
    model = v;
  endtask
  task automatic load_code(int v);
    dut_if.mode = MODE_SAW;
    dut_if.sweep_en = 1'b1;
    dut_if.start_code = 8'(v);
    dut_if.stop_code = 8'd0;
    expect_code(v);
    tick();
    chk("load_busy", dut_if.busy, 0);
    chk("load_code", dut_if.freq_ctrl, v);
    dut_if.sweep_en = 1'b0;
    dut_if.mode = MODE_MANUAL;
  endtask
  task automatic wait_hz(string tag, int exp);
    chk({tag, "_pend"}, dut_if.hz_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({tag, "_pend"}, dut_if.hz_valid, 0);
    end
    tick();
    chk({tag, "_valid"}, dut_if.hz_valid, 1);
    chk(tag, dut_if.freq_hz, exp);
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_ctrl"}, dut_if.freq_ctrl, 0);
    chk({tag, "_upd"}, dut_if.freq_upd, 0);
    chk({tag, "_busy"}, dut_if.busy, 0);
    chk({tag, "_hz"}, dut_if.freq_hz, 0);
    chk({tag, "_hzv"}, dut_if.hz_valid, 1);
  endtask
  // every freq_upd pulse must match the oldest expected code
  always @(negedge clk)
    if (dut_if.freq_upd === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0 && dut_if.freq_ctrl === exp_q[0]) else begin
        errors++;
        $error("FAIL upd_code observed=%0d expected=%0d", dut_if.freq_ctrl,
               exp_q.size() != 0 ? int'(exp_q[0]) : -1);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  initial begin
    dut_if.mode = MODE_MANUAL;
    dut_if.sweep_en = 1'b0;
    dut_if.key_up = 1'b0;
    dut_if.key_dn = 1'b0;
    dut_if.start_code = 8'd0;
    dut_if.stop_code = 8'd0;
    dut_if.step = 8'd0;
    dut_if.dwell = 16'd0;
    tick(2);
    chk_reset("rst");
    rst = 1'b0;
    dut_if.key_dn = 1'b1;
    tick();
    dut_if.key_dn = 1'b0;
    chk("sat_dn", dut_if.freq_ctrl, 0);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick();
      dut_if.key_up = 1'b1;
      expect_code(i);
      tick();
      dut_if.key_up = 1'b0;
    end
    chk("manual_code", dut_if.freq_ctrl, 3);
    wait_hz("hz_3", 1171);
    load_code(255);
    wait_hz("hz_255", 99609);
    dut_if.key_up = 1'b1;
    tick();
    dut_if.key_up = 1'b0;
    chk("sat_up", dut_if.freq_ctrl, 255);
    dut_if.key_up = 1'b1;
    dut_if.key_dn = 1'b1;
    tick();
    dut_if.key_up = 1'b0;
    dut_if.key_dn = 1'b0;
    chk("both_keys", dut_if.freq_ctrl, 255);
    dut_if.mode = MODE_HOLD;
    dut_if.key_dn = 1'b1;
    tick();
    dut_if.key_dn = 1'b0;
    dut_if.mode = MODE_MANUAL;
    chk("hold_mode", dut_if.freq_ctrl, 255);
    dut_if.key_dn = 1'b1;
    expect_code(254);
    tick();
    dut_if.key_dn = 1'b0;
    chk("key_dn", dut_if.freq_ctrl, 254);
    load_code(128);
    wait_hz("hz_128", 50000);
    load_code(1);
    wait_hz("hz_1", 390);
    load_code(255);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("restart_pend", dut_if.hz_valid, 0);
    end
    load_code(128);
    wait_hz("hz_restart", 50000);
    dut_if.mode = MODE_SAW;
    dut_if.start_code = 8'd10;
    dut_if.stop_code = 8'd20;
    dut_if.step = 8'd4;
    dut_if.dwell = 16'd3;
    dut_if.sweep_en = 1'b1;
    foreach (saw_seq[i]) expect_code(saw_seq[i]);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("saw_code", dut_if.freq_ctrl, saw_seq[i / 3]);
      chk("saw_busy", dut_if.busy, 1);
      if (i == 1) dut_if.stop_code = 8'd100;
      dut_if.key_up = (i == 4);
    end
    dut_if.sweep_en = 1'b0;
    tick();
    chk("saw_abort_busy", dut_if.busy, 0);
    chk("saw_abort_code", dut_if.freq_ctrl, 10);
    tick();
    chk("saw_frozen", dut_if.freq_ctrl, 10);
    dut_if.mode = MODE_TRI;
    dut_if.start_code = 8'd0;
    dut_if.stop_code = 8'd255;
    dut_if.step = 8'd100;
    dut_if.dwell = 16'd0;
    dut_if.sweep_en = 1'b1;
    foreach (tri_seq[i]) expect_code(tri_seq[i]);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tri_code", dut_if.freq_ctrl, tri_seq[i]);
      chk("tri_busy", dut_if.busy, 1);
      chk("tri_hz_pend", dut_if.hz_valid, 0);
    end
    dut_if.sweep_en = 1'b0;
    tick();
    chk("tri_abort_busy", dut_if.busy, 0);
    chk("tri_abort_code", dut_if.freq_ctrl, 100);
    tick();
    chk("tri_frozen", dut_if.freq_ctrl, 100);
    dut_if.mode = MODE_SAW;
    dut_if.start_code = 8'd50;
    dut_if.stop_code = 8'd50;
    dut_if.sweep_en = 1'b1;
    expect_code(50);
    tick();
    chk("eq_code", dut_if.freq_ctrl, 50);
    chk("eq_busy", dut_if.busy, 0);
    tick();
    chk("eq_busy2", dut_if.busy, 0);
    chk("eq_code2", dut_if.freq_ctrl, 50);
    dut_if.start_code = 8'd10;
    dut_if.stop_code = 8'd20;
    dut_if.step = 8'd4;
    dut_if.dwell = 16'd3;
    expect_code(10);
    tick();
    chk("pre_rst_busy", dut_if.busy, 1);
    tick();
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;
    dut_if.sweep_en = 1'b0;
    model = 0;
    tick();
    chk("q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Sequencing controller for the DDS frequency path. It owns the 8-bit frequency control word (`freq_ctrl`) and drives it from one of three sources: manual up/down key pulses, a continuous sawtooth sweep, or a triangle sweep between two codes. For every word it issues it also computes the matching output frequency in Hz, `freq_ctrl*100000 >> 8`, using a multicycle shift-add unit with a valid flag. It sits between the key/debounce front end and the phase accumulator and display logic, and runs in the 100 kHz domain.

## Interface
- `DWELL_W`, default 16: width of the dwell-time input.
- `clk_100kHz` input 1: system clock, 100 kHz.
- `rst` input 1: reset, synchronous, active-high; the block has one clock.
- `mode` input 2: 00 manual, 01 sawtooth sweep, 10 triangle sweep, 11 hold.
- `sweep_en` input 1: level; starts and keeps running a sweep in modes 01/10.
- `key_up`, `key_dn` input 1 each: single-cycle pulses, already debounced.
- `start_code` input 8: lower sweep bound.
- `stop_code` input 8: upper sweep bound.
- `step` input 8: code increment per sweep step; 0 is treated as 1.
- `dwell` input DWELL_W: cycles each code is held; 0 is treated as 1.
- `freq_ctrl` output 8: control word to the phase accumulator.
- `freq_upd` output 1: one-cycle pulse, high in the first cycle a new, different `freq_ctrl` value is visible.
- `busy` output 1: sweep in progress.
- `freq_hz` output 32: frequency of `freq_ctrl` in Hz, truncated.
- `hz_valid` output 1: `freq_hz` matches the current `freq_ctrl`.

## Operation
- Reset values: `freq_ctrl`=0, `freq_upd`=0, `busy`=0, `freq_hz`=0, `hz_valid`=1, FSM=IDLE, dwell counter=0.
- FSM states: IDLE, UP, DOWN.
- IDLE, mode 00:
  - `key_up` increments `freq_ctrl`, saturating at 255.
  - `key_dn` decrements `freq_ctrl`, saturating at 0.
  - Both keys in the same cycle: ignored.
  - A key at saturation: no change and no `freq_upd`.
- IDLE, mode 11: `freq_ctrl` is frozen and keys are ignored.
- IDLE, mode 01/10, with `sweep_en`=1:
  - Latch `start_code`, `stop_code`, `step` and `dwell` (0→1).
  - Load `freq_ctrl`=start, set `busy`=1, go to UP.
  - If start ≥ stop: load start, stay in IDLE, `busy` stays 0.
- UP state:
  - When the dwell count expires, next = min(`freq_ctrl`+step, stop). Compute the sum 9 bits wide so there is no wrap past 255.
  - If next == stop: in mode 01 the following step loads start (sawtooth wrap); in mode 10 go to DOWN.
- DOWN state:
  - Next = max(`freq_ctrl`−step, start), computed 9 bits wide with no underflow.
  - Reaching start → UP.
- Abort conditions, applied in UP/DOWN:
  - `sweep_en`=0 or a change of `mode` → IDLE the next cycle.
  - `freq_ctrl` holds its last value and `busy`=0.
  - Keys are ignored while `busy`=1.
- Changes to configuration inputs during a sweep have no effect until the next start.
- Hz unit:
  - Every `freq_upd` loads the new code and clears `hz_valid`.
  - It performs 8 shift-add iterations of `code × 100000`, then registers the result `>> 8` with truncation.
  - A new `freq_upd` during a computation restarts it; no stale result is ever flagged valid.

## Timing
- Control input sampled at edge N → `freq_ctrl`/`freq_upd` change at edge N+1.
- Sweep hold: each code is held exactly max(`dwell`,1) cycles. The first code (start) also gets a full dwell.
- Hz latency: `freq_upd` at cycle N → `hz_valid`=1 with the correct `freq_hz` at cycle N+9. `hz_valid`=0 for cycles N..N+8.
- Minimum sweep dwell of 1 means the Hz unit never settles; `hz_valid` stays low. This is legal behaviour.
- Reset asserted mid-sweep or mid-calculation: all outputs return to their reset values at the next edge.

## Structure
- Shared package `dds_pkg` holds:
  - mode encodings (MODE_MANUAL/SAW/TRI/HOLD)
  - the FSM state enum
  - REF_HZ=100000
  - ACC_SHIFT=8
  - CODE_W=8
- Sub-module `freq_hz_calc` is the sequential shift-add multiplier with a load/valid handshake. It is instantiated once; the FSM and dwell counter stay in the top.

## Test plan
- Manual mode, 3× `key_up` from reset → `freq_ctrl`=3, three `freq_upd` pulses; 9 cycles after the last pulse, `freq_hz`=1171, `hz_valid`=1.
- Manual mode at 255 with `key_up` → no change and no `freq_upd`. `key_up`+`key_dn` in the same cycle → ignored.
- Sawtooth, start=10, stop=20, step=4, dwell=3 → sequence 10,14,18,20,10, each held 3 cycles, `busy`=1.
- Triangle, start=0, stop=255, step=100, dwell=0 → 0,100,200,255,155,55,0,100, one cycle each. Deassert `sweep_en` mid-sweep → `busy`=0 the next cycle and the code is frozen.
- Hz check: codes 128→50000, 255→99609, 1→390. A second update arriving 4 cycles into a calculation → only the second result is flagged valid, 9 cycles after its `freq_upd`.
- Sweep request with start=50, stop=50 → `freq_ctrl`=50, `busy` stays 0. Reset asserted mid-sweep → all outputs return to their reset values at the next edge.
